// File: rtl/mult_div_unit.sv
// Iterative signed 32x32 multiply / divide unit producing HI/LO (34-edge latency).
// Optional macro DIVZERO_EXC_EN: divide-by-zero short-circuits with a DivZero pulse.
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic        Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        Done,
    output logic        DivZero,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [1:0] {IDLE, MULT, DIV, FIX} state_t;

    state_t      state, state_next;
    logic        op_q;
    logic        neg_a, neg_b;
    logic [31:0] opnd;
    logic [63:0] prod;
    logic [31:0] rem, quo;
    logic [4:0]  count;
    logic        done_q;
    logic [31:0] hi_q, lo_q;

    logic [31:0] mag_a, mag_b;
    logic [32:0] mult_sum;
    logic [32:0] div_shift;
    logic [31:0] div_diff;
    logic        div_ge;
    logic [63:0] prod_signed;

    assign mag_a = A[31] ? (32'd0 - A) : A;
    assign mag_b = B[31] ? (32'd0 - B) : B;

    // One shift-add step: the multiplier occupies prod's low half and drains out as the product grows in.
    assign mult_sum    = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, opnd} : 33'd0);
    assign div_shift   = {rem, quo[31]};
    assign div_ge      = (div_shift >= {1'b0, opnd});
    assign div_diff    = div_shift[31:0] - opnd;
    assign prod_signed = (neg_a ^ neg_b) ? (64'd0 - prod) : prod;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (Start) begin
                    state_next = Op ? DIV : MULT;
`ifdef DIVZERO_EXC_EN
                    if (Op && (B == 32'd0))
                        state_next = FIX;
`endif
                end
            end
            MULT, DIV: begin
                if (count == 5'd31)
                    state_next = FIX;
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

`ifdef DIVZERO_EXC_EN
    logic dz_q;
    logic div_zero_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dz_q       <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            div_zero_q <= (state == FIX) && dz_q;
            if (state == IDLE && Start)
                dz_q <= Op && (B == 32'd0);
        end
    end

    assign DivZero = div_zero_q;
`else
    logic dz_q;
    assign dz_q    = 1'b0;
    assign DivZero = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q   <= 1'b0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            opnd   <= 32'd0;
            prod   <= 64'd0;
            rem    <= 32'd0;
            quo    <= 32'd0;
            count  <= 5'd0;
            done_q <= 1'b0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        op_q  <= Op;
                        neg_a <= A[31];
                        neg_b <= B[31];
                        opnd  <= Op ? mag_b : mag_a;
                        prod  <= {32'd0, mag_b};
                        rem   <= 32'd0;
                        quo   <= mag_a;
                        count <= 5'd0;
                    end
                end
                MULT: begin
                    prod  <= {mult_sum, prod[31:1]};
                    count <= count + 5'd1;
                end
                DIV: begin
                    rem   <= div_ge ? div_diff : div_shift[31:0];
                    quo   <= {quo[30:0], div_ge};
                    count <= count + 5'd1;
                end
                FIX: begin
                    done_q <= 1'b1;
                    // Remainder follows the dividend's sign; quotient sign is the XOR of operand signs.
                    if (!dz_q) begin
                        if (op_q) begin
                            lo_q <= (neg_a ^ neg_b) ? (32'd0 - quo) : quo;
                            hi_q <= neg_a ? (32'd0 - rem) : rem;
                        end else begin
                            {hi_q, lo_q} <= prod_signed;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign Busy = (state != IDLE);
    assign Done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random ops vs. an arithmetic model.
// Honours DIVZERO_EXC_EN the same way the design does.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic        Op;
    logic [31:0] A, B;
    logic        Busy, Done, DivZero;
    logic [31:0] HI, LO;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] hi_exp = 32'd0;
    logic [31:0] lo_exp = 32'd0;

    mult_div_unit dut (
        .clk     (clk),
        .reset   (reset),
        .Start   (Start),
        .Op      (Op),
        .A       (A),
        .B       (B),
        .Busy    (Busy),
        .Done    (Done),
        .DivZero (DivZero),
        .HI      (HI),
        .LO      (LO)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference results from plain signed arithmetic; divide-by-zero follows the architectural rules.
    task automatic model(input logic op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] mh, output logic [31:0] ml,
                         output logic dz, output int lat);
        int     sa, sb;
        longint p;
        sa  = a;
        sb  = b;
        dz  = 1'b0;
        lat = 33;
        mh  = hi_exp;
        ml  = lo_exp;
        if (!op) begin
            p = longint'(sa) * longint'(sb);
            {mh, ml} = p;
        end else if (sb == 0) begin
`ifdef DIVZERO_EXC_EN
            dz  = 1'b1;
            lat = 1;
`else
            ml = (sa >= 0) ? 32'hFFFF_FFFF : 32'h0000_0001;
            mh = a;
`endif
        end else if (a == 32'h8000_0000 && sb == -1) begin
            ml = 32'h8000_0000;
            mh = 32'd0;
        end else begin
            ml = sa / sb;
            mh = sa % sb;
        end
    endtask

    // Starts one operation (E0 is the next rising edge) and follows it to Done.
    task automatic apply_stimulus(input logic op, input logic [31:0] a, input logic [31:0] b, input bit repulse);
        logic [31:0] mh, ml;
        logic        dz;
        int          lat;
        int          seen;
        model(op, a, b, mh, ml, dz, lat);
        Start = 1'b1;
        Op    = op;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        Start = 1'b0;
        Op    = $urandom_range(0, 1);
        A     = $urandom;
        B     = $urandom;
        check_output("busy_after_e0", {63'd0, Busy}, 64'd1);
        check_output("done_low_at_e0", {63'd0, Done}, 64'd0);
        seen = 0;
        for (int e = 1; e <= 40; e++) begin
            if (repulse && e == 10) begin
                Start = 1'b1;
                Op    = ~op;
                A     = $urandom;
                B     = $urandom | 32'd1;
            end
            if (repulse && e == 11)
                Start = 1'b0;
            @(posedge clk);
            #1;
            if (e == 16 && !Done)
                check_output("hilo_hold_mid", {HI, LO}, {hi_exp, lo_exp});
            if (Done) begin
                seen = e;
                break;
            end
        end
        Start = 1'b0;
        check_output("done_latency", 64'(seen), 64'(lat));
        check_output("busy_at_done", {63'd0, Busy}, 64'd0);
        check_output("divzero_flag", {63'd0, DivZero}, {63'd0, dz});
        hi_exp = mh;
        lo_exp = ml;
        check_output("hi_lo_result", {HI, LO}, {hi_exp, lo_exp});
    endtask

    initial begin
        logic        op;
        logic [31:0] a, b;
        int          sel;
        int          done_count;

        reset = 1'b0;
        Start = 1'b0;
        Op    = 1'b0;
        A     = 32'd0;
        B     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_status", {61'd0, Busy, Done, DivZero}, 64'd0);
        check_output("reset_hilo", {HI, LO}, 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] directed cases");
        apply_stimulus(1'b0, 32'hFFFF_FFFD, 32'd7, 1'b0);
        apply_stimulus(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
        apply_stimulus(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        apply_stimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        apply_stimulus(1'b1, 32'd5, 32'd0, 1'b0);
        apply_stimulus(1'b1, 32'hFFFF_FFF0, 32'd0, 1'b0);
        apply_stimulus(1'b0, 32'd12345, 32'hFFFF_FF00, 1'b1);
        apply_stimulus(1'b1, 32'd1000, 32'd7, 1'b1);

        $display("[TB] reset during divide");
        Start = 1'b1;
        Op    = 1'b1;
        A     = 32'd100;
        B     = 32'd3;
        @(posedge clk);
        #1;
        Start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_output("abort_status", {61'd0, Busy, Done, DivZero}, 64'd0);
        check_output("abort_hilo", {HI, LO}, 64'd0);
        hi_exp = 32'd0;
        lo_exp = 32'd0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        done_count = 0;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk);
            #1;
            if (Done)
                done_count++;
        end
        check_output("abort_no_done", 64'(done_count), 64'd0);
        apply_stimulus(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

        $display("[TB] random operations");
        for (int i = 0; i < 24; i++) begin
            op  = 1'($urandom_range(0, 1));
            a   = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'd0 - $urandom_range(1, 15);
                3:       begin a = 32'h8000_0000; b = $urandom; end
                default: b = $urandom;
            endcase
            apply_stimulus(op, a, b, 1'b0);
        end

        @(posedge clk);
        #1;
        check_output("final_done_low", {63'd0, Done}, 64'd0);
        check_output("final_busy_low", {63'd0, Busy}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
